// File: rtl/encoder4to2_seq.sv
// encoder4to2_seq: sequential 4-to-2 encoder with a pending-request register
// and a valid/ack handshake toward the consumer.
// A request on I is latched into pend (when E=1) and later granted as a
// 2-bit index on A with valid=1. The grant is held until ack, at which point
// the granted pend bit is cleared. A new request on the same line in the same
// cycle keeps that bit set.
// Optional macro ROUND_ROBIN_EN: rotating selection starting after the last
// granted index. Without it, the highest set pend index wins.
module encoder4to2_seq (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       E,
   input  logic [3:0] I,
   input  logic       ack,
   output logic [1:0] A,
   output logic       valid,
   output logic [3:0] pend
);

   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] HOLD = 2'b01;

   logic [1:0] state_reg;
   logic [1:0] state_next;
   logic [1:0] a_reg;
   logic [1:0] a_next;
   logic       valid_reg;
   logic       valid_next;
   logic [3:0] pend_reg;
   logic [3:0] pend_next;
   logic [3:0] clr;
   logic [3:0] set_req;
   logic [1:0] sel;
   logic       grant;

   // A grant is issued from IDLE whenever the registered pend is non-empty.
   assign grant = (state_reg == IDLE) && (pend_reg != 4'b0000);

   // Per-line pending update: clear the acknowledged index, then OR in new
   // requests so that a simultaneous set on the same line wins.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_pend
         assign clr[gi]       = valid_reg && ack && (a_reg == 2'(gi));
         assign set_req[gi]   = E && I[gi];
         assign pend_next[gi] = (pend_reg[gi] && !clr[gi]) || set_req[gi];
      end
   endgenerate

`ifdef ROUND_ROBIN_EN
   logic [1:0] last_reg;
   logic [1:0] last_next;
   logic [1:0] rr_idx;
   logic       rr_found;

   // Rotating search: first set pend bit at or after (last+1), wrapping.
   always_comb begin
      sel      = 2'b00;
      rr_found = 1'b0;
      rr_idx   = 2'b00;
      for (int k = 0; k < 4; k++) begin
         rr_idx = last_reg + 2'd1 + k[1:0];
         if (!rr_found && pend_reg[rr_idx]) begin
            sel      = rr_idx;
            rr_found = 1'b1;
         end
      end
   end

   // Remember the most recent grant to rotate the search start.
   always_comb begin
      last_next = grant ? sel : last_reg;
   end

   // Last-grant register; resets to 3 so the first search starts at 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_reg <= 2'b11;
      end else begin
         last_reg <= last_next;
      end
   end
`else
   // Fixed priority: later (higher) indices overwrite, so the highest wins.
   always_comb begin
      sel = 2'b00;
      for (int k = 0; k < 4; k++) begin
         if (pend_reg[k]) begin
            sel = k[1:0];
         end
      end
   end
`endif

   // State and output registers; reset discards any grant and all requests.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         a_reg     <= 2'b00;
         valid_reg <= 1'b0;
         pend_reg  <= 4'b0000;
      end else begin
         state_reg <= state_next;
         a_reg     <= a_next;
         valid_reg <= valid_next;
         pend_reg  <= pend_next;
      end
   end

   // Next-state logic: IDLE grants on non-empty pend, HOLD waits for ack.
   always_comb begin
      state_next = IDLE;
      case (state_reg)
         IDLE:    state_next = grant ? HOLD : IDLE;
         HOLD:    state_next = ack ? IDLE : HOLD;
         default: state_next = IDLE;
      endcase
   end

   // Output logic: load A on grant, keep A stable otherwise; valid follows HOLD.
   always_comb begin
      a_next     = a_reg;
      valid_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (grant) begin
               a_next     = sel;
               valid_next = 1'b1;
            end
         end
         HOLD:    valid_next = !ack;
         default: valid_next = 1'b0;
      endcase
   end

   assign A     = a_reg;
   assign valid = valid_reg;
   assign pend  = pend_reg;

endmodule

// File: tb/tb_encoder4to2_seq.sv
// Testbench for encoder4to2_seq: directed scenarios followed by random
// traffic, checked against a cycle-level behavioural model through a
// per-cycle snapshot queue and a grant queue consumed on each rising valid.
module tb_encoder4to2_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       E = 1'b0;
   logic [3:0] I = 4'b0000;
   logic       ack = 1'b0;
   logic [1:0] A;
   logic       valid;
   logic [3:0] pend;

   always #5 clk = ~clk;

   encoder4to2_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .E     (E),
      .I     (I),
      .ack   (ack),
      .A     (A),
      .valid (valid),
      .pend  (pend)
   );

   typedef struct packed {
      logic       v;
      logic [1:0] a;
      logic [3:0] p;
   } snap_t;

   snap_t exp_q[$];
   int    grant_q[$];
   int    total = 0;
   int    bad = 0;
   bit    rst_cmd = 1'b0;

   // Behavioural model: set of pending lines, current owner (-1 = none).
   bit    m_pend[4];
   int    m_owner = -1;
   int    m_a = 0;
   int    m_last = 3;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // Predict the state after the coming rising edge from the current model.
   task automatic model_edge(input bit rst, input bit e, input logic [3:0] i, input bit ak);
      bit         old[4];
      int         pick;
      int         idx;
      logic [3:0] packed_p;
      if (!rst) begin
         for (int k = 0; k < 4; k++) m_pend[k] = 1'b0;
         m_owner = -1;
         m_a     = 0;
         m_last  = 3;
      end else begin
         for (int k = 0; k < 4; k++) old[k] = m_pend[k];
         for (int k = 0; k < 4; k++)
            m_pend[k] = (old[k] && !(m_owner == k && ak)) || (e && i[k]);
         if (m_owner >= 0) begin
            if (ak) m_owner = -1;
         end else begin
            pick = -1;
`ifdef ROUND_ROBIN_EN
            for (int k = 1; k <= 4; k++) begin
               idx = (m_last + k) % 4;
               if (pick < 0 && old[idx]) pick = idx;
            end
`else
            for (int k = 3; k >= 0; k--) begin
               idx = k;
               if (pick < 0 && old[idx]) pick = idx;
            end
`endif
            if (pick >= 0) begin
               m_owner = pick;
               m_a     = pick;
               m_last  = pick;
               grant_q.push_back(pick);
            end
         end
      end
      for (int k = 0; k < 4; k++) packed_p[k] = m_pend[k];
      exp_q.push_back('{v: (m_owner >= 0), a: 2'(m_a), p: packed_p});
   endtask

   // Drive one cycle of inputs at the falling edge, then wait for the rising edge.
   task automatic step(input bit e, input logic [3:0] i, input bit ak);
      @(negedge clk);
      rst_n = rst_cmd;
      E     = e;
      I     = i;
      ack   = ak;
      model_edge(rst_cmd, e, i, ak);
      @(posedge clk);
   endtask

   // Monitor: compare every cycle's outputs and each new grant index.
   snap_t cur;
   logic  prev_valid = 1'b0;
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         cur = exp_q.pop_front();
         check("valid", int'(valid), int'(cur.v));
         check("A", int'(A), int'(cur.a));
         check("pend", int'(pend), int'(cur.p));
      end
      if (valid && !prev_valid) begin
         if (grant_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL grant: got unexpected grant A=%0d expected none", A);
         end else begin
            check("grant_A", int'(A), grant_q.pop_front());
         end
      end
      prev_valid = valid;
   end

   initial begin
      #2 rst_n = 1'b0;
      rst_cmd = 1'b0;
      step(1'b0, 4'b0000, 1'b0);
      step(1'b0, 4'b0000, 1'b0);
      rst_cmd = 1'b1;

      // Single request held until ack.
      step(1'b1, 4'b0100, 1'b0);
      step(1'b0, 4'b0000, 1'b0);
      #2 check("hold_A", int'(A), 2);
      check("hold_valid", int'(valid), 1);
      repeat (5) step(1'b0, 4'b0000, 1'b0);
      step(1'b0, 4'b0000, 1'b1);
      step(1'b0, 4'b0000, 1'b0);

      // Three requests drained with ack held high.
      step(1'b1, 4'b1011, 1'b0);
      repeat (12) step(1'b0, 4'b0000, 1'b1);
      #2 check("drain_pend", int'(pend), 0);

      // Capture disabled, then enabled for one cycle.
      repeat (3) step(1'b0, 4'b1111, 1'b0);
      step(1'b1, 4'b1111, 1'b0);
      #2 check("enable_pend", int'(pend), 15);
      repeat (12) step(1'b0, 4'b0000, 1'b1);

      // Set wins over clear, then regrant after one idle cycle.
      step(1'b1, 4'b0010, 1'b0);
      step(1'b0, 4'b0000, 1'b0);
      step(1'b0, 4'b0000, 1'b0);
      step(1'b1, 4'b0010, 1'b1);
      #2 check("setwin_valid", int'(valid), 0);
      check("setwin_pend1", int'(pend[1]), 1);
      step(1'b0, 4'b0000, 1'b0);
      #2 check("regrant_A", int'(A), 1);
      check("regrant_valid", int'(valid), 1);
      step(1'b0, 4'b0000, 1'b1);
      step(1'b0, 4'b0000, 1'b0);

      // Asynchronous reset while holding a grant.
      step(1'b1, 4'b0110, 1'b0);
      step(1'b0, 4'b0000, 1'b0);
      #3 rst_n = 1'b0;
      rst_cmd = 1'b0;
      #1 check("async_valid", int'(valid), 0);
      check("async_A", int'(A), 0);
      check("async_pend", int'(pend), 0);
      step(1'b0, 4'b0000, 1'b0);
      rst_cmd = 1'b1;
      repeat (3) step(1'b0, 4'b0000, 1'b0);
      #2 check("post_reset_valid", int'(valid), 0);

      // Ack held in IDLE clears nothing; single-cycle grant afterwards.
      repeat (3) step(1'b0, 4'b0000, 1'b1);
      step(1'b1, 4'b0001, 1'b1);
      step(1'b0, 4'b0000, 1'b1);
      #2 check("ackidle_A", int'(A), 0);
      check("ackidle_valid", int'(valid), 1);
      step(1'b0, 4'b0000, 1'b1);
      #2 check("ackidle_clear", int'(valid), 0);
      step(1'b0, 4'b0000, 1'b0);

      // Random traffic.
      repeat (400) begin
         step(1'($urandom_range(0, 3) != 0),
              4'($urandom & $urandom),
              1'($urandom_range(0, 2) == 0));
      end
      repeat (12) step(1'b0, 4'b0000, 1'b1);
      repeat (2) step(1'b0, 4'b0000, 1'b0);

      #2 check("snap_queue_empty", exp_q.size(), 0);
      check("grant_queue_empty", grant_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
